// File: rtl/switch_debouncer.sv
// Switch conditioner: per-bit synchroniser, debounce counter, registered rise/fall pulses and event outputs.
// Define SWITCH_DEBOUNCER_EVENT_LATCH_EN for sticky event_mask/event_valid with event_ack clearing.

module switch_debouncer_lane #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise,
   output logic fall,
   output logic accept
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_WIDTH-1:0]   cnt;
   logic                   sync;

   assign sync   = sync_q[SYNC_STAGES-1];
   // Accept on the last mismatching cycle; the counter is reset there, so it never wraps.
   assign accept = (sync != stable) && (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         rise   <= accept & sync;
         fall   <= accept & ~sync;
         if (sync == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= sync;
            cnt    <= '0;
         end else begin
            cnt <= cnt + CNT_WIDTH'(1);
         end
      end
   end
endmodule

module switch_debouncer #(
   parameter int NUM_SWITCHES    = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic                    SYSTEMCLOCK,
   input  logic                    PUSH_BUTTON_RESET_RAW,
   input  logic [NUM_SWITCHES-1:0] switch_raw,
   output logic [NUM_SWITCHES-1:0] switch_stable,
   output logic [NUM_SWITCHES-1:0] switch_rise,
   output logic [NUM_SWITCHES-1:0] switch_fall,
   output logic                    event_valid,
   output logic [NUM_SWITCHES-1:0] event_mask,
   input  logic                    event_ack
);
   logic [NUM_SWITCHES-1:0] accept;
   logic [NUM_SWITCHES-1:0] mask_nxt;

   switch_debouncer_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_lane [NUM_SWITCHES-1:0] (
      .clk   (SYSTEMCLOCK),
      .rst_n (PUSH_BUTTON_RESET_RAW),
      .raw   (switch_raw),
      .stable(switch_stable),
      .rise  (switch_rise),
      .fall  (switch_fall),
      .accept(accept)
   );

`ifdef SWITCH_DEBOUNCER_EVENT_LATCH_EN
   // An ack replaces the mask with the edges registered on the same clock, so none are dropped.
   always_comb begin
      mask_nxt = event_mask | accept;
      if (event_valid && event_ack) mask_nxt = accept;
   end
`else
   logic unused_ack;
   assign unused_ack = event_ack;
   always_comb begin
      mask_nxt = accept;
   end
`endif

   always_ff @(posedge SYSTEMCLOCK or negedge PUSH_BUTTON_RESET_RAW) begin
      if (!PUSH_BUTTON_RESET_RAW) begin
         event_mask  <= '0;
         event_valid <= 1'b0;
      end else begin
         event_mask  <= mask_nxt;
         event_valid <= |mask_nxt;
      end
   end
endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: stimulus pushes expected pulse records, a monitor pops and compares.
module tb_switch_debouncer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] raw = 4'hF;
   logic [3:0] stable, rise, fall, mask;
   logic       valid;
   logic       ack = 1'b0;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      int         cyc;
      logic [3:0] stable;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] mask;
   } exp_t;
   exp_t q[$];

   switch_debouncer #(
      .NUM_SWITCHES(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(3)
   ) dut (
      .SYSTEMCLOCK          (clk),
      .PUSH_BUTTON_RESET_RAW(rst_n),
      .switch_raw           (raw),
      .switch_stable        (stable),
      .switch_rise          (rise),
      .switch_fall          (fall),
      .event_valid          (valid),
      .event_mask           (mask),
      .event_ack            (ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge right after changing raw: stable shows the new value after 10 more edges.
   task automatic expect_evt(input logic [3:0] s, input logic [3:0] r, input logic [3:0] f,
                             input logic [3:0] m);
      exp_t e;
      e.cyc = cyc + 10;
      e.stable = s;
      e.rise = r;
      e.fall = f;
      e.mask = m;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: fires whenever the DUT presents a pulse (or, in pulse mode, any event).
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ((|rise) || (|fall)
`ifndef SWITCH_DEBOUNCER_EVENT_LATCH_EN
                    || valid || (|mask)
`endif
                   )) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {16'h0, stable, rise, fall, mask}, 32'hFFFF_FFFF);
         end else begin
            e = q.pop_front();
            chk("evt_cycle", cyc, e.cyc);
            chk("evt_stable", {28'h0, stable}, {28'h0, e.stable});
            chk("evt_rise", {28'h0, rise}, {28'h0, e.rise});
            chk("evt_fall", {28'h0, fall}, {28'h0, e.fall});
            chk("evt_mask", {28'h0, mask}, {28'h0, e.mask});
            chk("evt_valid", {31'h0, valid}, 32'h1);
         end
      end
   end

   initial begin
      // 1. reset state, then power-up acceptance of raw=F
      #2;
      chk("reset_outputs", {15'h0, stable, rise, fall, mask, valid}, 32'h0);
      wait_cyc(3);
      chk("reset_hold", {15'h0, stable, rise, fall, mask, valid}, 32'h0);
      rst_n = 1'b1;
      expect_evt(4'hF, 4'hF, 4'h0, 4'hF);
      wait_cyc(14);

      // 2. bit 0 falls (ack held high: ignored in pulse mode)
`ifndef SWITCH_DEBOUNCER_EVENT_LATCH_EN
      ack = 1'b1;
`endif
      raw[0] = 1'b0;
      expect_evt(4'hE, 4'h0, 4'h1, 4'h1);
      wait_cyc(14);
      ack = 1'b0;

      // 3. bit 1 glitches low for 7 cycles: one short of acceptance
      raw[1] = 1'b0;
      wait_cyc(7);
      raw[1] = 1'b1;
      wait_cyc(15);
      chk("glitch_stable", {28'h0, stable}, 32'hE);

      // 4. bit 2 falls, then bounces 1,0 and settles at 1
      raw[2] = 1'b0;
      expect_evt(4'hA, 4'h0, 4'h4, 4'h4);
      wait_cyc(14);
      raw[2] = 1'b1;
      wait_cyc(3);
      raw[2] = 1'b0;
      wait_cyc(3);
      raw[2] = 1'b1;
      expect_evt(4'hE, 4'h4, 4'h0, 4'h4);
      wait_cyc(14);
      chk("bounce_stable", {28'h0, stable}, 32'hE);

      // 5. bit 3 falls, then reset lands mid-debounce of its return to 1
      raw[3] = 1'b0;
      expect_evt(4'h6, 4'h0, 4'h8, 4'h8);
      wait_cyc(14);
      raw[3] = 1'b1;
      wait_cyc(7);
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {15'h0, stable, rise, fall, mask, valid}, 32'h0);
      wait_cyc(3);
      rst_n = 1'b1;
      expect_evt(4'hE, 4'hE, 4'h0, 4'hE);
      wait_cyc(9);
      chk("no_credit_stable", {28'h0, stable}, 32'h0);
      wait_cyc(5);

`ifdef SWITCH_DEBOUNCER_EVENT_LATCH_EN
      // 6. sticky events with acknowledge
      chk("latch_sticky_E", {27'h0, valid, mask}, 32'h1E);
      ack = 1'b1;
      wait_cyc(1);
      ack = 1'b0;
      chk("latch_ack_clear", {27'h0, valid, mask}, 32'h0);
      raw[0] = 1'b1;
      expect_evt(4'hF, 4'h1, 4'h0, 4'h1);
      wait_cyc(14);
      chk("latch_hold_1", {27'h0, valid, mask}, 32'h11);
      raw[3] = 1'b0;
      expect_evt(4'h7, 4'h0, 4'h8, 4'h9);
      wait_cyc(14);
      chk("latch_hold_9", {27'h0, valid, mask}, 32'h19);
      raw[1] = 1'b0;
      expect_evt(4'h5, 4'h0, 4'h2, 4'h2);
      wait_cyc(9);
      ack = 1'b1;
      wait_cyc(1);
      chk("latch_ack_edge", {27'h0, valid, mask}, 32'h12);
      wait_cyc(1);
      ack = 1'b0;
      chk("latch_ack_final", {27'h0, valid, mask}, 32'h0);
      wait_cyc(3);
      ack = 1'b1;
      wait_cyc(1);
      ack = 1'b0;
      chk("latch_idle_ack", {27'h0, valid, mask}, 32'h0);
`endif

      wait_cyc(20);
      chk("scoreboard_drained", q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
